// File: rtl/led_pkg.sv
// led_pkg: shared state encoding, pixel geometry and brightness scaling for the LED serializer.
package led_pkg;
  typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} led_state_t;
  localparam int PIXEL_W = 24;
  localparam int CH_W = 8;
  localparam int CH_N = PIXEL_W / CH_W;
  function automatic logic [PIXEL_W-1:0] scale_px(input logic [PIXEL_W-1:0] px, input logic [CH_W-1:0] b);
    logic [2*CH_W-1:0] p;
    scale_px = '0;
    for (int i = 0; i < CH_N; i++) begin
      p = (2*CH_W)'(px[i*CH_W +: CH_W]) * (2*CH_W)'(b);
      scale_px[i*CH_W +: CH_W] = p[2*CH_W-1:CH_W];
    end
  endfunction
endpackage

// File: rtl/led_slot_timer.sv
// led_slot_timer: counts ticks inside a bit slot and strobes the end of the high phase and of the slot.
module led_slot_timer #(
  parameter int SLOT_TICKS = 3,
  parameter int HIGH1_TICKS = 2,
  parameter int HIGH0_TICKS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic run,
  input  logic cur_bit,
  output logic slot_end,
  output logic high_end
);
  localparam int TW = $clog2(SLOT_TICKS + 1);
  logic [TW-1:0] tick_cnt_q, tick_cnt_d, cnt_inc;
  always_comb begin
    cnt_inc = (tick_cnt_q == TW'(SLOT_TICKS)) ? tick_cnt_q : tick_cnt_q + 1'b1;
    high_end = run && tick && cnt_inc == TW'(cur_bit ? HIGH1_TICKS : HIGH0_TICKS);
    slot_end = run && tick && cnt_inc == TW'(SLOT_TICKS);
    tick_cnt_d = (!run || slot_end) ? '0 : tick ? cnt_inc : tick_cnt_q;
  end
  always_ff @(posedge clk) tick_cnt_q <= rst ? '0 : tick_cnt_d;
endmodule

// File: rtl/led_pixel_serializer.sv
// led_pixel_serializer: GRB pixels in over valid/ready, pulse-width-encoded LED stream out, latch gap per frame.
// Optional LED_BRIGHTNESS_EN adds a brightness input that scales each channel when a pixel is loaded.
module led_pixel_serializer import led_pkg::*; #(
  parameter int SLOT_TICKS = 3,
  parameter int HIGH1_TICKS = 2,
  parameter int HIGH0_TICKS = 1,
  parameter int LATCH_TICKS = 64,
  parameter int FRAME_PIXELS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [PIXEL_W-1:0] pixel_data,
  input  logic               pixel_valid,
`ifdef LED_BRIGHTNESS_EN
  input  logic [CH_W-1:0]    brightness,
`endif
  output logic               pixel_ready,
  output logic               serial_out,
  output logic               busy,
  output logic               underrun,
  output logic               frame_done
);
  localparam int BW = $clog2(PIXEL_W);
  localparam int PW = FRAME_PIXELS > 1 ? $clog2(FRAME_PIXELS) : 1;
  localparam int LW = LATCH_TICKS > 1 ? $clog2(LATCH_TICKS) : 1;
  led_state_t state_q, state_d;
  logic [PIXEL_W-1:0] hold_q, hold_d, shift_q, shift_d, load_px;
  logic hold_valid_q, hold_valid_d, serial_q, serial_d, underrun_q, underrun_d, frame_done_q, frame_done_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [LW-1:0] latch_cnt_q, latch_cnt_d;
  logic slot_end, high_end, take, load, last_bit, last_pix;
  led_slot_timer #(.SLOT_TICKS(SLOT_TICKS), .HIGH1_TICKS(HIGH1_TICKS), .HIGH0_TICKS(HIGH0_TICKS)) u_timer (
    .clk(clk), .rst(rst), .tick(tick), .run(state_q == HIGH || state_q == LOW),
    .cur_bit(shift_q[PIXEL_W-1]), .slot_end(slot_end), .high_end(high_end)
  );
`ifdef LED_BRIGHTNESS_EN
  assign load_px = scale_px(hold_q, brightness);
`else
  assign load_px = hold_q;
`endif
  assign pixel_ready = !hold_valid_q;
  assign serial_out = serial_q;
  assign busy = state_q != IDLE;
  assign underrun = underrun_q;
  assign frame_done = frame_done_q;
  always_comb begin
    last_bit = bit_cnt_q == BW'(PIXEL_W - 1);
    last_pix = pix_cnt_q == PW'(FRAME_PIXELS - 1);
    load = hold_valid_q && ((state_q == IDLE && tick) || (state_q == LOW && slot_end && last_bit && !last_pix));
    take = pixel_valid && !hold_valid_q;
    hold_valid_d = take || (hold_valid_q && !load);
    hold_d = take ? pixel_data : hold_q;
    state_d = state_q;
    shift_d = shift_q;
    bit_cnt_d = bit_cnt_q;
    pix_cnt_d = pix_cnt_q;
    latch_cnt_d = latch_cnt_q;
    serial_d = serial_q;
    underrun_d = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: if (load) begin
        shift_d = load_px;
        bit_cnt_d = '0;
        pix_cnt_d = '0;
        serial_d = 1'b1;
        state_d = HIGH;
      end
      HIGH: if (high_end) begin
        serial_d = 1'b0;
        state_d = LOW;
      end
      LOW: if (slot_end) begin
        if (!last_bit) begin
          shift_d = shift_q << 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          serial_d = 1'b1;
          state_d = HIGH;
        end else if (load) begin
          shift_d = load_px;
          bit_cnt_d = '0;
          pix_cnt_d = pix_cnt_q + 1'b1;
          serial_d = 1'b1;
          state_d = HIGH;
        end else begin
          underrun_d = !last_pix;
          latch_cnt_d = '0;
          state_d = LATCH;
        end
      end
      LATCH: if (tick) begin
        if (latch_cnt_q == LW'(LATCH_TICKS - 1)) begin
          frame_done_d = 1'b1;
          pix_cnt_d = '0;
          state_d = IDLE;
        end else latch_cnt_d = latch_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q <= '0;
      hold_valid_q <= 1'b0;
      shift_q <= '0;
      bit_cnt_q <= '0;
      pix_cnt_q <= '0;
      latch_cnt_q <= '0;
      serial_q <= 1'b0;
      underrun_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      hold_valid_q <= hold_valid_d;
      shift_q <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      latch_cnt_q <= latch_cnt_d;
      serial_q <= serial_d;
      underrun_q <= underrun_d;
      frame_done_q <= frame_done_d;
    end
  end
endmodule
